// File: rtl/opb_reg_pkg.sv
// ==========================================================================
// opb_reg_pkg : shared OPB register-slave types, offsets and byte-lane merge
// Rev 1.0
// ==========================================================================
`default_nettype none

package opb_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } OPB_ACK_FSM_T;

  localparam logic [1:0] REG_SHADOW = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_LIVE   = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_AUTO_BIT   = 1;

  // OPB lane 0 is the most significant byte of the user word
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [0:3]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[31-8*i -: 8] = new_v[31-8*i -: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/opb_slave_ack_fsm.sv
// ==========================================================================
// opb_slave_ack_fsm : OPB address decode, single-ack handshake, read-data register
// Rev 1.0
// ==========================================================================
`default_nettype none

module opb_slave_ack_fsm
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0000_000F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:31] i_abus,
  input  logic        i_rnw,
  input  logic        i_select,
  input  logic [31:0] i_rd_data,
  output logic [1:0]  o_rd_offset,
  output logic [1:0]  o_wr_offset,
  output logic        o_wr_en,
  output logic [0:31] o_sl_dbus,
  output logic        o_sl_xfer_ack,
  output logic        o_sl_err_ack,
  output logic        o_sl_retry,
  output logic        o_sl_tout_sup
);

  OPB_ACK_FSM_T state_q, state_d;
  logic         rnw_q, rnw_d;
  logic [1:0]   offset_q, offset_d;
  logic [0:31]  dbus_q, dbus_d;
  logic         ge_base, le_high, hit;

  // Extra LSB keeps both bounds as strict compares, valid for any window placement
  assign ge_base = {i_abus, 1'b1} > {C_BASEADDR, 1'b0};
  assign le_high = {i_abus, 1'b0} < {C_HIGHADDR, 1'b1};
  assign hit     = i_select & ge_base & le_high;

  assign o_rd_offset = i_abus[28:29];

  always_comb begin
    state_d  = state_q;
    rnw_d    = rnw_q;
    offset_d = offset_q;
    dbus_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d  = ACK;
          rnw_d    = i_rnw;
          offset_d = o_rd_offset;
          if (i_rnw) dbus_d = i_rd_data;
        end
      end
      ACK:     state_d = WAIT;
      WAIT:    if (!i_select) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rnw_q    <= 1'b0;
      offset_q <= 2'd0;
      dbus_q   <= '0;
    end else begin
      state_q  <= state_d;
      rnw_q    <= rnw_d;
      offset_q <= offset_d;
      dbus_q   <= dbus_d;
    end
  end

  assign o_sl_xfer_ack = (state_q == ACK);
  assign o_wr_en       = (state_q == ACK) & ~rnw_q;
  assign o_wr_offset   = offset_q;
  assign o_sl_dbus     = dbus_q;
  assign o_sl_err_ack  = 1'b0;
  assign o_sl_retry    = 1'b0;
  assign o_sl_tout_sup = 1'b0;

endmodule

`default_nettype wire

// File: rtl/opb_register_ppc2simulink.sv
// ==========================================================================
// opb_register_ppc2simulink : PPC-written shadow register committed to fabric
// Rev 1.0
// ==========================================================================
`default_nettype none

module opb_register_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_000F,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [31:0] C_INIT_VALUE = 32'h0000_0000,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic [31:0] user_data_out,
  output logic        user_data_valid
);

  localparam int    unused_widths = C_OPB_AWIDTH + C_OPB_DWIDTH;
  localparam string unused_family = C_FAMILY;

  logic        unused_seq;
  logic [31:0] shadow_q, shadow_d;
  logic        auto_q, auto_d;
  logic [31:0] user_data_q, user_data_d;
  logic [31:0] commit_cnt_q, commit_cnt_d;
  logic        valid_q, valid_d;
  logic        commit;
  logic [31:0] wdata, rd_data, ctrl_rd;
  logic [1:0]  rd_offset, wr_offset;
  logic        wr_en;

  assign unused_seq = OPB_seqAddr;
  assign wdata      = OPB_DBus;

  opb_slave_ack_fsm #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_ack_fsm (
    .clk           (OPB_Clk),
    .rst           (OPB_Rst),
    .i_abus        (OPB_ABus),
    .i_rnw         (OPB_RNW),
    .i_select      (OPB_select),
    .i_rd_data     (rd_data),
    .o_rd_offset   (rd_offset),
    .o_wr_offset   (wr_offset),
    .o_wr_en       (wr_en),
    .o_sl_dbus     (Sl_DBus),
    .o_sl_xfer_ack (Sl_xferAck),
    .o_sl_err_ack  (Sl_errAck),
    .o_sl_retry    (Sl_retry),
    .o_sl_tout_sup (Sl_toutSup)
  );

  always_comb begin
    ctrl_rd                = '0;
    ctrl_rd[CTRL_AUTO_BIT] = auto_q;
    unique case (rd_offset)
      REG_SHADOW: rd_data = shadow_q;
      REG_CTRL:   rd_data = ctrl_rd;
      REG_LIVE:   rd_data = user_data_q;
      default:    rd_data = commit_cnt_q;
    endcase
  end

  // A commit always publishes the post-write shadow; COMMIT reads back as 0
  always_comb begin
    shadow_d = shadow_q;
    auto_d   = auto_q;
    commit   = 1'b0;
    if (wr_en) begin
      unique case (wr_offset)
        REG_SHADOW: begin
          shadow_d = be_merge(shadow_q, wdata, OPB_BE);
          commit   = auto_q;
        end
        REG_CTRL: begin
          commit = OPB_BE[3] & wdata[CTRL_COMMIT_BIT];
          if (OPB_BE[3]) auto_d = wdata[CTRL_AUTO_BIT];
        end
        default: ;
      endcase
    end
    user_data_d  = commit ? shadow_d : user_data_q;
    valid_d      = commit;
    commit_cnt_d = commit_cnt_q + 32'(commit);
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      shadow_q     <= C_INIT_VALUE;
      auto_q       <= 1'b0;
      user_data_q  <= C_INIT_VALUE;
      commit_cnt_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      auto_q       <= auto_d;
      user_data_q  <= user_data_d;
      commit_cnt_q <= commit_cnt_d;
      valid_q      <= valid_d;
    end
  end

  assign user_data_out   = user_data_q;
  assign user_data_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_opb_register_ppc2simulink.sv
// ==========================================================================
// tb_opb_register_ppc2simulink : vector table, random traffic vs register model
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_opb_register_ppc2simulink;

  localparam logic [31:0] INIT = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:31] abus = '0;
  logic [0:3]  be = '0;
  logic [0:31] dbus = '0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seq = 1'b0;
  logic [0:31] sl_dbus;
  logic        sl_ack, sl_err, sl_retry, sl_tout;
  logic [31:0] user_out;
  logic        user_valid;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0, vcount = 0, dbus_bad = 0, tie_bad = 0;

  logic [31:0] m_shadow, m_live, m_count;
  logic        m_auto;

  typedef struct {
    logic [31:0] addr;
    logic        rnw;
    logic [31:0] wdata;
    logic [0:3]  be;
    logic [31:0] exp_rd;
    logic [31:0] exp_live;
    int          exp_pulses;
  } vec_t;

  vec_t tbl[17];

  opb_register_ppc2simulink #(
    .C_BASEADDR   (32'h0000_0000),
    .C_HIGHADDR   (32'h0000_000F),
    .C_OPB_AWIDTH (32),
    .C_OPB_DWIDTH (32),
    .C_INIT_VALUE (INIT),
    .C_FAMILY     ("virtex5")
  ) dut (
    .OPB_Clk         (clk),
    .OPB_Rst         (rst),
    .OPB_ABus        (abus),
    .OPB_BE          (be),
    .OPB_DBus        (dbus),
    .OPB_RNW         (rnw),
    .OPB_select      (sel),
    .OPB_seqAddr     (seq),
    .Sl_DBus         (sl_dbus),
    .Sl_xferAck      (sl_ack),
    .Sl_errAck       (sl_err),
    .Sl_retry        (sl_retry),
    .Sl_toutSup      (sl_tout),
    .user_data_out   (user_out),
    .user_data_valid (user_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sl_ack) ack_cnt++;
    if (user_valid) vcount++;
    if (!sl_ack && sl_dbus != '0) dbus_bad++;
    if (sl_err || sl_retry || sl_tout) tie_bad++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mmerge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [0:3] b);
    logic [31:0] r, mask;
    r = old_v;
    for (int k = 0; k < 4; k++) begin
      mask = 32'hFF << (24 - 8 * k);
      if (b[k]) r = (r & ~mask) | (new_v & mask);
    end
    return r;
  endfunction

  // Register-level model: reads see pre-write state, commits publish post-write shadow
  task automatic model_apply(input logic [31:0] addr, input logic r, input logic [31:0] wd,
                             input logic [0:3] b, output logic [31:0] rd, output int pulses);
    logic [31:0] ctrl_new;
    pulses = 0;
    rd = 32'h0;
    case (addr[3:2])
      2'd0: rd = m_shadow;
      2'd1: rd = {30'h0, m_auto, 1'b0};
      2'd2: rd = m_live;
      default: rd = m_count;
    endcase
    if (!r) begin
      if (addr[3:2] == 2'd0) begin
        m_shadow = mmerge(m_shadow, wd, b);
        if (m_auto) pulses = 1;
      end else if (addr[3:2] == 2'd1) begin
        ctrl_new = mmerge({30'h0, m_auto, 1'b0}, wd, b);
        if (ctrl_new[0]) pulses = 1;
        m_auto = ctrl_new[1];
      end
      if (pulses == 1) begin
        m_live  = m_shadow;
        m_count = m_count + 32'd1;
      end
    end
  endtask

  task automatic xfer(input logic [31:0] addr, input logic r, input logic [31:0] wd,
                      input logic [0:3] b, output logic [31:0] rdata, output int acks);
    int a0;
    bit got;
    a0 = ack_cnt;
    rdata = 32'h0;
    got = 0;
    @(posedge clk); #1;
    abus = addr; rnw = r; dbus = r ? 32'h0 : wd; be = b; sel = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (sl_ack) begin
        got = 1;
        rdata = sl_dbus;
      end
    end
    @(posedge clk); #1;
    sel = 1'b0; rnw = 1'b0; dbus = '0; be = '0; abus = '0;
    repeat (2) @(posedge clk);
    #1;
    acks = ack_cnt - a0;
  endtask

  task automatic run_checked(input string tag, input logic [31:0] addr, input logic r,
                             input logic [31:0] wd, input logic [0:3] b);
    logic [31:0] rd, exp_rd;
    int acks, pulses, v0;
    v0 = vcount;
    model_apply(addr, r, wd, b, exp_rd, pulses);
    xfer(addr, r, wd, b, rd, acks);
    check({tag, "_ack"}, 32'(acks), 32'd1);
    if (r) check({tag, "_rd"}, rd, exp_rd);
    check({tag, "_live"}, user_out, m_live);
    check({tag, "_pulses"}, 32'(vcount - v0), 32'(pulses));
  endtask

  initial begin
    logic [31:0] rd, dummy_rd;
    int acks, v0, a0, dummy_p;
    bit got;

    tbl[0]  = '{32'h8, 1'b1, 32'h0,         4'b1111, 32'hA5A50001, 32'hA5A50001, 0};
    tbl[1]  = '{32'hC, 1'b1, 32'h0,         4'b1111, 32'h00000000, 32'hA5A50001, 0};
    tbl[2]  = '{32'h0, 1'b0, 32'h12345678,  4'b1111, 32'h0,        32'hA5A50001, 0};
    tbl[3]  = '{32'h0, 1'b1, 32'h0,         4'b1111, 32'h12345678, 32'hA5A50001, 0};
    tbl[4]  = '{32'h4, 1'b0, 32'h00000001,  4'b1111, 32'h0,        32'h12345678, 1};
    tbl[5]  = '{32'hC, 1'b1, 32'h0,         4'b1111, 32'h00000001, 32'h12345678, 0};
    tbl[6]  = '{32'h4, 1'b0, 32'h00000002,  4'b1111, 32'h0,        32'h12345678, 0};
    tbl[7]  = '{32'h4, 1'b1, 32'h0,         4'b1111, 32'h00000002, 32'h12345678, 0};
    tbl[8]  = '{32'h0, 1'b0, 32'hFFFFFFFF,  4'b0100, 32'h0,        32'h12FF5678, 1};
    tbl[9]  = '{32'hC, 1'b1, 32'h0,         4'b1111, 32'h00000002, 32'h12FF5678, 0};
    tbl[10] = '{32'h8, 1'b0, 32'hDEADBEEF,  4'b1111, 32'h0,        32'h12FF5678, 0};
    tbl[11] = '{32'h8, 1'b1, 32'h0,         4'b1111, 32'h12FF5678, 32'h12FF5678, 0};
    tbl[12] = '{32'h0, 1'b0, 32'h00000000,  4'b0000, 32'h0,        32'h12FF5678, 1};
    tbl[13] = '{32'hC, 1'b1, 32'h0,         4'b1111, 32'h00000003, 32'h12FF5678, 0};
    tbl[14] = '{32'h4, 1'b0, 32'h00000003,  4'b1111, 32'h0,        32'h12FF5678, 1};
    tbl[15] = '{32'h4, 1'b0, 32'h00000001,  4'b1111, 32'h0,        32'h12FF5678, 1};
    tbl[16] = '{32'h4, 1'b1, 32'h0,         4'b1111, 32'h00000000, 32'h12FF5678, 0};

    m_shadow = INIT; m_live = INIT; m_count = 0; m_auto = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_live", user_out, INIT);
    check("reset_valid", 32'(user_valid), 32'd0);
    check("reset_ack", 32'(sl_ack), 32'd0);
    check("reset_dbus", sl_dbus, 32'h0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      v0 = vcount;
      model_apply(tbl[i].addr, tbl[i].rnw, tbl[i].wdata, tbl[i].be, dummy_rd, dummy_p);
      xfer(tbl[i].addr, tbl[i].rnw, tbl[i].wdata, tbl[i].be, rd, acks);
      check($sformatf("vec%0d_ack", i), 32'(acks), 32'd1);
      if (tbl[i].rnw) check($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_live", i), user_out, tbl[i].exp_live);
      check($sformatf("vec%0d_pulses", i), 32'(vcount - v0), 32'(tbl[i].exp_pulses));
    end

    for (int n = 0; n < 40; n++) begin
      run_checked($sformatf("rnd%0d", n), {28'h0, 2'($urandom_range(0, 3)), 2'b00},
                  1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
    end

    // Master keeps select for three cycles after the ack
    a0 = ack_cnt;
    got = 0;
    @(posedge clk); #1;
    abus = 32'h8; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (sl_ack) got = 1;
    end
    repeat (4) @(posedge clk);
    #1;
    sel = 1'b0; rnw = 1'b0; abus = '0; be = '0;
    repeat (2) @(posedge clk);
    #1;
    check("hold_select_acks", 32'(ack_cnt - a0), 32'd1);

    a0 = ack_cnt;
    @(posedge clk); #1;
    abus = 32'h10; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    sel = 1'b0; rnw = 1'b0; abus = '0; be = '0;
    repeat (2) @(posedge clk);
    #1;
    check("out_of_window_acks", 32'(ack_cnt - a0), 32'd0);

    // Counter wrap
    force dut.commit_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.commit_cnt_q;
    m_count = 32'hFFFF_FFFF;
    run_checked("wrap_pre", 32'hC, 1'b1, 32'h0, 4'b1111);
    run_checked("wrap_commit", 32'h4, 1'b0, {30'h0, m_auto, 1'b1}, 4'b1111);
    run_checked("wrap_post", 32'hC, 1'b1, 32'h0, 4'b1111);
    check("wrap_count_zero", m_count, 32'h0);
    run_checked("live_ro_wr", 32'h8, 1'b0, 32'h0BAD_F00D, 4'b1111);

    // Reset during the ack cycle of a commit write
    run_checked("pre_rst_shadow", 32'h0, 1'b0, 32'hCAFE_F00D, 4'b1111);
    got = 0;
    @(posedge clk); #1;
    abus = 32'h4; rnw = 1'b0; dbus = 32'h1; be = 4'b1111; sel = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (sl_ack) got = 1;
    end
    check("rst_ack_seen", 32'(got), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_ack", 32'(sl_ack), 32'd0);
    check("rst_async_live", user_out, INIT);
    check("rst_async_valid", 32'(user_valid), 32'd0);
    check("rst_async_dbus", sl_dbus, 32'h0);
    v0 = vcount;
    a0 = ack_cnt;
    @(posedge clk); #1;
    sel = 1'b0; dbus = '0; be = '0; abus = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_valid", 32'(vcount - v0), 32'd0);
    check("rst_no_ack", 32'(ack_cnt - a0), 32'd0);
    check("rst_live_hold", user_out, INIT);
    m_shadow = INIT; m_live = INIT; m_count = 0; m_auto = 1'b0;
    run_checked("post_rst_count", 32'hC, 1'b1, 32'h0, 4'b1111);
    run_checked("post_rst_shadow", 32'h0, 1'b1, 32'h0, 4'b1111);

    check("dbus_zero_outside_ack", 32'(dbus_bad), 32'd0);
    check("tied_outputs_zero", 32'(tie_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
